// File: rtl/game_count.sv
// rtl/game_count.sv - credit countdown with prescaled tick, boost rate and red/yellow lamps
module game_count #(
    parameter int TICK_DIV   = 1,
    parameter int WARN_LEVEL = 10,
    parameter int WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [WIDTH-1:0] money,
    input  logic             boost,
    output logic             red,
    output logic             yellow,
    output logic [WIDTH-1:0] remain
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] WARN_V  = WIDTH'(WARN_LEVEL);

    logic [PW-1:0]    prescaler;
    logic             tick;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] next_remain;

    assign tick = (remain != '0) && (prescaler == PRE_MAX);
    assign step = boost ? WIDTH'(2) : WIDTH'(1);

    // Saturating subtract: a step larger than the balance lands on zero, never wraps.
    assign next_remain = (remain > step) ? (remain - step) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remain    <= '0;
            prescaler <= '0;
        end else if (set) begin
            remain    <= money;
            prescaler <= '0;
        end else if (remain == '0) begin
            prescaler <= '0;
        end else if (tick) begin
            remain    <= next_remain;
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign red    = (remain == '0);
    assign yellow = (remain != '0) && (remain < WARN_V);

endmodule

// File: tb/tb_game_count.sv
// tb/tb_game_count.sv - directed self-checking bench for game_count
module tb_game_count;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       set;
    logic [9:0] money;
    logic       boost;
    logic       red, yellow;
    logic [9:0] remain;
    logic       red4, yellow4;
    logic [9:0] remain4;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    game_count #(.TICK_DIV(1), .WARN_LEVEL(10), .WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .set(set), .money(money), .boost(boost),
        .red(red), .yellow(yellow), .remain(remain)
    );

    // Second instance with a slower tick shares the stimulus to exercise the prescaler.
    game_count #(.TICK_DIV(4), .WARN_LEVEL(10), .WIDTH(10)) dut4 (
        .clk(clk), .rst_n(rst_n), .set(set), .money(money), .boost(boost),
        .red(red4), .yellow(yellow4), .remain(remain4)
    );

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] got_remain,
                         input logic got_red, input logic got_yellow, input int exp);
        logic [11:0] got_v, exp_v;
        got_v = {got_red, got_yellow, got_remain};
        exp_v = {(exp == 0), (exp > 0 && exp < 10), 10'(exp)};
        tests++;
        assert (got_v === exp_v) else begin
            fails++;
            $error("FAIL %s: red/yellow/remain got %b/%b/%0d expected %b/%b/%0d",
                   tag, got_red, got_yellow, got_remain, exp_v[11], exp_v[10], exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; set = 1'b0; money = '0; boost = 1'b0;

        // Reset and idle
        step_clk();
        check("reset", remain, red, yellow, 0);
        check("reset_div4", remain4, red4, yellow4, 0);
        rst_n = 1'b1;
        repeat (3) step_clk();
        check("idle", remain, red, yellow, 0);

        // Load 15 and count down to empty; money goes X once set drops
        set = 1'b1; money = 10'd15;
        step_clk();
        check("load15", remain, red, yellow, 15);
        check("load15_div4", remain4, red4, yellow4, 15);
        set = 1'b0; money = 'x;
        for (int k = 1; k <= 15; k++) begin
            step_clk();
            check($sformatf("down15_%0d", k), remain, red, yellow, 15 - k);
            check($sformatf("div4_%0d", k), remain4, red4, yellow4, 15 - k / 4);
        end
        repeat (3) step_clk();
        check("hold0", remain, red, yellow, 0);

        // Load 50: ten normal ticks then ten boosted ticks
        set = 1'b1; money = 10'd50;
        step_clk();
        set = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step_clk();
            check($sformatf("run_n_%0d", k), remain, red, yellow, 50 - k);
        end
        boost = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step_clk();
            check($sformatf("run_b_%0d", k), remain, red, yellow, 40 - 2 * k);
        end

        // Reload mid-run while boosted
        step_clk();
        check("pre_reload", remain, red, yellow, 18);
        set = 1'b1; money = 10'd20;
        step_clk();
        check("reload", remain, red, yellow, 20);
        set = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step_clk();
            check($sformatf("reload_b_%0d", k), remain, red, yellow, 20 - 2 * k);
        end

        // Saturation at both ends
        set = 1'b1; money = 10'd3;
        step_clk();
        check("sat_load3", remain, red, yellow, 3);
        set = 1'b0;
        step_clk();
        check("sat_1", remain, red, yellow, 1);
        step_clk();
        check("sat_0", remain, red, yellow, 0);
        step_clk();
        check("sat_hold", remain, red, yellow, 0);
        set = 1'b1; money = 10'd1023;
        step_clk();
        check("load_max", remain, red, yellow, 1023);
        set = 1'b0; boost = 1'b0;
        step_clk();
        check("max_dec", remain, red, yellow, 1022);

        // Set with zero money empties the counter
        set = 1'b1; money = 10'd0;
        step_clk();
        check("load0", remain, red, yellow, 0);
        set = 1'b0;
        step_clk();
        check("load0_hold", remain, red, yellow, 0);

        // Reset beats set; held set reloads without counting
        rst_n = 1'b0; set = 1'b1; money = 10'd50;
        step_clk();
        check("rst_over_set", remain, red, yellow, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            check($sformatf("set_held_%0d", k), remain, red, yellow, 50);
        end
        set = 1'b0;
        step_clk();
        check("after_set_1", remain, red, yellow, 49);
        step_clk();
        check("after_set_2", remain, red, yellow, 48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
